// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong types, widths and default constants
//
// Purpose : common definitions for the Pong display, AI and scoring blocks.
// Contents: scorekeeper state enum, score width, default game constants,
//           and the packed ball/paddle position field ranges.
package pong_pkg;

    typedef enum logic {
        PLAY     = 1'b0,
        WIN_HOLD = 1'b1
    } state_t;

    localparam int SCORE_W = 4;

    localparam int DEF_WIN_SCORE   = 7;
    localparam int DEF_HOLD_CYCLES = 60;

    // Packed position word: Y in [23:12], X in [11:0].
    localparam int POS_W     = 24;
    localparam int POS_Y_MSB = 23;
    localparam int POS_Y_LSB = 12;
    localparam int POS_X_MSB = 11;
    localparam int POS_X_LSB = 0;

    function automatic logic [POS_Y_MSB-POS_Y_LSB:0] pos_y(input logic [POS_W-1:0] pos);
        return pos[POS_Y_MSB:POS_Y_LSB];
    endfunction

    function automatic logic [POS_X_MSB-POS_X_LSB:0] pos_x(input logic [POS_W-1:0] pos);
        return pos[POS_X_MSB:POS_X_LSB];
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - one-bit rising-edge detector
//
// Purpose: flags the cycle in which d is high and was low at the previous edge.
// Ports  : clkS   in  clock
//          Reset  in  asynchronous active-high reset
//          d      in  level input
//          rise   out d & ~(d registered); a long high level gives one flag
module rise_detect (
    input  logic clkS,
    input  logic Reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clkS or posedge Reset) begin
        if (Reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - Pong match scorekeeper with win hold
//
// Purpose: counts player/computer points from the ball tracker's scoring
//          flags, detects a game win, holds win for HOLD_CYCLES and then
//          clears the points and resumes play.
// Ports  : clkS     in   system clock
//          Reset    in   asynchronous active-high reset
//          PScore   in   player-scored flag
//          CScore   in   computer-scored flag
//          score    in   any-score flag, counted on its rising edge
//          PPoints  out  player points in the current game
//          CPoints  out  computer points in the current game
//          PGames   out  player games won (wraps)
//          CGames   out  computer games won (wraps)
//          PWon     out  player won the most recent game
//          CWon     out  computer won the most recent game
//          win      out  game-over hold to the ball tracker
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic               clkS,
    input  logic               Reset,
    input  logic               PScore,
    input  logic               CScore,
    input  logic               score,
    output logic [SCORE_W-1:0] PPoints,
    output logic [SCORE_W-1:0] CPoints,
    output logic [SCORE_W-1:0] PGames,
    output logic [SCORE_W-1:0] CGames,
    output logic               PWon,
    output logic               CWon,
    output logic               win
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [SCORE_W-1:0] WIN_PTS   = SCORE_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               point_ev;
    logic               first_point;
    logic [SCORE_W-1:0] p_next;
    logic [SCORE_W-1:0] c_next;

    rise_detect u_score_rise (
        .clkS  (clkS),
        .Reset (Reset),
        .d     (score),
        .rise  (point_ev)
    );

    assign p_next      = PPoints + 1'b1;
    assign c_next      = CPoints + 1'b1;
    assign first_point = (PPoints == '0) && (CPoints == '0);

    always_ff @(posedge clkS or posedge Reset) begin
        if (Reset) begin
            state    <= PLAY;
            hold_cnt <= '0;
            PPoints  <= '0;
            CPoints  <= '0;
            PGames   <= '0;
            CGames   <= '0;
            PWon     <= 1'b0;
            CWon     <= 1'b0;
            win      <= 1'b0;
        end else begin
            case (state)
                PLAY: begin
                    // Exactly one flag must be set; both/neither is a no-op.
                    if (point_ev && (PScore != CScore)) begin
                        if (first_point) begin
                            PWon <= 1'b0;
                            CWon <= 1'b0;
                        end
                        if (PScore) begin
                            PPoints <= p_next;
                            if (p_next == WIN_PTS) begin
                                // Placed after the clear so a one-point game still flags the winner.
                                PWon     <= 1'b1;
                                PGames   <= PGames + 1'b1;
                                win      <= 1'b1;
                                hold_cnt <= HOLD_LOAD;
                                state    <= WIN_HOLD;
                            end
                        end else begin
                            CPoints <= c_next;
                            if (c_next == WIN_PTS) begin
                                CWon     <= 1'b1;
                                CGames   <= CGames + 1'b1;
                                win      <= 1'b1;
                                hold_cnt <= HOLD_LOAD;
                                state    <= WIN_HOLD;
                            end
                        end
                    end
                end
                WIN_HOLD: begin
                    // Loaded with HOLD_CYCLES-1 at the winning edge, so win
                    // falls exactly HOLD_CYCLES edges later.
                    if (hold_cnt == '0) begin
                        win     <= 1'b0;
                        PPoints <= '0;
                        CPoints <= '0;
                        state   <= PLAY;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - self-checking bench for score_keeper
module tb_score_keeper;

    localparam int WS = 3;
    localparam int HC = 4;

    logic       clkS = 1'b0;
    logic       Reset;
    logic       PScore, CScore, score;
    logic [3:0] PPoints, CPoints, PGames, CGames;
    logic       PWon, CWon, win;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: a game is a pair of tallies plus a countdown
    // of how many cycles of celebration remain.
    int m_pp, m_cp, m_pg, m_cg, m_pw, m_cw, m_win_left, m_prev;

    score_keeper #(.WIN_SCORE(WS), .HOLD_CYCLES(HC)) dut (
        .clkS    (clkS),
        .Reset   (Reset),
        .PScore  (PScore),
        .CScore  (CScore),
        .score   (score),
        .PPoints (PPoints),
        .CPoints (CPoints),
        .PGames  (PGames),
        .CGames  (CGames),
        .PWon    (PWon),
        .CWon    (CWon),
        .win     (win)
    );

    always #5 clkS = ~clkS;

    task automatic m_reset();
        m_pp = 0; m_cp = 0; m_pg = 0; m_cg = 0;
        m_pw = 0; m_cw = 0; m_win_left = 0; m_prev = 0;
    endtask

    task automatic m_clock(input int s, input int p, input int c);
        int ev;
        ev = (s != 0 && m_prev == 0) ? 1 : 0;
        m_prev = s;
        if (m_win_left > 0) begin
            m_win_left = m_win_left - 1;
            if (m_win_left == 0) begin
                m_pp = 0;
                m_cp = 0;
            end
        end else if (ev != 0 && p != c) begin
            if (m_pp == 0 && m_cp == 0) begin
                m_pw = 0;
                m_cw = 0;
            end
            if (p != 0) m_pp = m_pp + 1; else m_cp = m_cp + 1;
            if (m_pp == WS) begin
                m_pw = 1; m_pg = (m_pg + 1) % 16; m_win_left = HC;
            end else if (m_cp == WS) begin
                m_cw = 1; m_cg = (m_cg + 1) % 16; m_win_left = HC;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input int exp);
        logic [3:0] e;
        e = 4'(exp);
        n_vec++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".PPoints"}, PPoints, m_pp);
        chk({tag, ".CPoints"}, CPoints, m_cp);
        chk({tag, ".PGames"},  PGames,  m_pg);
        chk({tag, ".CGames"},  CGames,  m_cg);
        chk({tag, ".PWon"},    {3'b0, PWon}, m_pw);
        chk({tag, ".CWon"},    {3'b0, CWon}, m_cw);
        chk({tag, ".win"},     {3'b0, win},  (m_win_left > 0) ? 1 : 0);
    endtask

    task automatic cyc(input string tag, input int s, input int p, input int c);
        @(negedge clkS);
        score  = (s != 0);
        PScore = (p != 0);
        CScore = (c != 0);
        @(posedge clkS);
        m_clock(s, p, c);
        #1;
        check_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear with no clock.
    task automatic mid_reset(input string tag);
        @(negedge clkS);
        score = 1'b0; PScore = 1'b0; CScore = 1'b0;
        #2 Reset = 1'b1;
        m_reset();
        #1;
        check_all(tag);
        @(negedge clkS);
        Reset = 1'b0;
    endtask

    task automatic win_game_p(input string tag);
        for (int k = 0; k < WS; k++) begin
            cyc(tag, 1, 1, 0);
            if (k < WS - 1) cyc(tag, 0, 0, 0);
        end
        for (int h = 0; h < HC; h++) cyc(tag, 0, 0, 0);
    endtask

    initial begin
        Reset = 1'b1; score = 1'b0; PScore = 1'b0; CScore = 1'b0;
        m_reset();
        repeat (2) @(posedge clkS);
        #1;
        check_all("por");
        @(negedge clkS);
        Reset = 1'b0;

        // Basic counting to a player win.
        for (int k = 1; k <= WS; k++) begin
            cyc("basic", 1, 1, 0);
            chk("basic.pp_const", PPoints, k);
            if (k < WS) cyc("basic.idle", 0, 0, 0);
        end
        chk("basic.win_set", {3'b0, win}, 1);
        chk("basic.pwon_set", {3'b0, PWon}, 1);
        chk("basic.pgames1", PGames, 1);
        for (int h = 1; h < HC; h++) begin
            cyc("hold", 0, 0, 0);
            chk("hold.win_high", {3'b0, win}, 1);
        end
        cyc("hold_end", 0, 0, 0);
        chk("hold_end.win_low", {3'b0, win}, 0);
        chk("hold_end.pp_zero", PPoints, 0);
        chk("hold_end.pwon_held", {3'b0, PWon}, 1);
        chk("hold_end.pgames_held", PGames, 1);

        // Level score held and invalid flag combinations.
        for (int i = 0; i < 5; i++) cyc("level", 1, 0, 1);
        chk("level.cp_one", CPoints, 1);
        cyc("idle", 0, 0, 0);
        cyc("both", 1, 1, 1);
        cyc("idle", 0, 0, 0);
        cyc("neither", 1, 0, 0);
        cyc("idle", 0, 0, 0);
        chk("invalid.cp", CPoints, 1);
        chk("invalid.pp", PPoints, 0);

        // Computer wins, then pulses during the hold are ignored.
        for (int k = 0; k < WS - 1; k++) begin
            cyc("cwin", 1, 0, 1);
            cyc("cwin.idle", 0, 0, 0);
        end
        chk("cwin.win", {3'b0, win}, 1);
        chk("cwin.cgames", CGames, 1);
        cyc("hold_ev", 1, 0, 1);
        chk("hold_ev.cp", CPoints, WS);
        for (int h = 0; h < HC; h++) cyc("hold_ev.tail", 0, 0, 0);
        chk("hold_ev.cp_cleared", CPoints, 0);

        // Game-total wrap: player goes from 1 to 16 -> 0 after 15 wins.
        for (int g = 0; g < 15; g++) win_game_p("wrap");
        chk("wrap.pgames_zero", PGames, 0);
        chk("wrap.pwon", {3'b0, PWon}, 1);
        cyc("wrap.next", 1, 0, 1);
        chk("wrap.pwon_cleared", {3'b0, PWon}, 0);
        cyc("idle", 0, 0, 0);

        // Reset at hold cycle 2, then normal counting resumes.
        mid_reset("pre");
        for (int k = 0; k < WS; k++) begin
            cyc("mh", 1, 1, 0);
            if (k < WS - 1) cyc("mh.idle", 0, 0, 0);
        end
        cyc("mh.h1", 0, 0, 0);
        mid_reset("mh.reset");
        chk("mh.win_zero", {3'b0, win}, 0);
        cyc("mh.after", 1, 1, 0);
        chk("mh.pp_one", PPoints, 1);
        cyc("idle", 0, 0, 0);

        // Random traffic against the model, biased toward valid points.
        for (int i = 0; i < 600; i++) begin
            int s, p, c;
            s = ($urandom_range(0, 2) == 0) ? 1 : 0;
            p = $urandom_range(0, 1);
            c = ($urandom_range(0, 4) == 0) ? p : 1 - p;
            cyc("rand", s, p, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
